id_ex_reg: RTL and testbench

Decode-to-execute pipeline register for the RV32 five-stage core. Sits between decode and execute: accepts a decoded instruction under a valid/ready handshake, resolves both source operands from the register-file read ports or the hazard unit's forward outputs, and presents a registered payload to execute as `valid_E`/`type_E`/`rd_E`/`load_E`. Those signals feed back into the RAW hazard/forward unit. Honours the hazard unit's `stall_D`, supports branch-redirect flush, and keeps two performance counters.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/operand_fwd_mux.sv | 17 +
 rtl/id_ex_reg.sv | 120 ++++++++++++
 tb/tb_id_ex_reg.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared decode/execute pipeline definitions: widths, type-class masks and
// the registered decode-to-execute payload.
package pipe_pkg;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  localparam logic [4:0] TYPE_NORS2_MSK = 5'b00111;
  localparam logic [4:0] TYPE_NORD_MSK  = 5'b11000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [4:0]        typ;
    logic [4:0]        rd;
    logic              load;
    logic [CTRL_W-1:0] ctrl;
  } de_payload_t;

  function automatic logic has_rd(input logic [4:0] t);
    return (t & TYPE_NORD_MSK) == 5'd0;
  endfunction

  function automatic logic has_rs2(input logic [4:0] t);
    return (t & TYPE_NORS2_MSK) == 5'd0;
  endfunction
endpackage

// File: rtl/operand_fwd_mux.sv
// Source operand select: x0 reads as zero, then hazard-unit forward,
// then register-file read data.
module operand_fwd_mux #(
  parameter int XLEN = pipe_pkg::XLEN
) (
  input  logic [4:0]      i_idx,
  input  logic [XLEN-1:0] i_rf_data,
  input  logic            i_fwd_vld,
  input  logic [XLEN-1:0] i_fwd_data,
  output logic [XLEN-1:0] o_op
);
  always_comb begin
    o_op = i_rf_data;
    if (i_idx == 5'd0)  o_op = '0;
    else if (i_fwd_vld) o_op = i_fwd_data;
  end
endmodule

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with operand forwarding, load-use
// stall, redirect flush and issue/stall performance counters.
module id_ex_reg
  import pipe_pkg::*;
#(
  // payload struct widths come from pipe_pkg; keep these equal to it
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_D,
  output logic              ready_D,
  input  logic [XLEN-1:0]   pc_D,
  input  logic [XLEN-1:0]   imm_D,
  input  logic [4:0]        type_D,
  input  logic [4:0]        rs1_D,
  input  logic [4:0]        rs2_D,
  input  logic [4:0]        rd_D,
  input  logic              load_D,
  input  logic [CTRL_W-1:0] ctrl_D,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              stall_D,
  input  logic              valid_forward_rs1,
  input  logic              valid_forward_rs2,
  input  logic [XLEN-1:0]   forward_rs1,
  input  logic [XLEN-1:0]   forward_rs2,
  input  logic              ready_E,
  output logic              valid_E,
  output logic [XLEN-1:0]   pc_E,
  output logic [XLEN-1:0]   imm_E,
  output logic [XLEN-1:0]   op1_E,
  output logic [XLEN-1:0]   op2_E,
  output logic [4:0]        type_E,
  output logic [4:0]        rd_E,
  output logic              load_E,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic [31:0]       cnt_issue,
  output logic [31:0]       cnt_stall
);
  logic              r_valid_E;
  de_payload_t       r_pl;
  logic [31:0]       r_cnt_issue;
  logic [31:0]       r_cnt_stall;

  logic              w_fire_in;
  logic              w_fire_out;
  de_payload_t       w_pl_nxt;
  logic [1:0][4:0]       w_idx;
  logic [1:0][XLEN-1:0]  w_rf;
  logic [1:0]            w_fv;
  logic [1:0][XLEN-1:0]  w_fd;
  logic [1:0][XLEN-1:0]  w_op;

  assign w_fire_out = r_valid_E & ready_E;
  assign ready_D    = ~stall_D & ~flush & (~r_valid_E | ready_E);
  assign w_fire_in  = valid_D & ready_D;

  assign w_idx = {rs2_D, rs1_D};
  assign w_rf  = {rf_rdata2, rf_rdata1};
  assign w_fv  = {valid_forward_rs2, valid_forward_rs1};
  assign w_fd  = {forward_rs2, forward_rs1};

  // op2 is resolved even for no-rs2 classes; execute picks imm_E instead
  for (genvar g = 0; g < 2; g++) begin : g_opnd
    operand_fwd_mux #(.XLEN(XLEN)) u_mux (
      .i_idx      (w_idx[g]),
      .i_rf_data  (w_rf[g]),
      .i_fwd_vld  (w_fv[g]),
      .i_fwd_data (w_fd[g]),
      .o_op       (w_op[g])
    );
  end

  always_comb begin
    w_pl_nxt      = '0;
    w_pl_nxt.pc   = pc_D;
    w_pl_nxt.imm  = imm_D;
    w_pl_nxt.op1  = w_op[0];
    w_pl_nxt.op2  = w_op[1];
    w_pl_nxt.typ  = type_D;
    w_pl_nxt.rd   = rd_D;
    w_pl_nxt.load = load_D;
    w_pl_nxt.ctrl = ctrl_D;
  end

  // Payload is not cleared on flush/bubble: the hazard unit masks stale
  // rd/type/load through valid_E.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_E   <= 1'b0;
      r_pl        <= '0;
      r_cnt_issue <= '0;
      r_cnt_stall <= '0;
    end else begin
      if (flush)           r_valid_E <= 1'b0;
      else if (w_fire_in) begin
        r_valid_E <= 1'b1;
        r_pl      <= w_pl_nxt;
      end else if (w_fire_out) r_valid_E <= 1'b0;

      if (w_fire_in)                   r_cnt_issue <= r_cnt_issue + 32'd1;
      if (valid_D & stall_D & ~flush)  r_cnt_stall <= r_cnt_stall + 32'd1;
    end
  end

  assign valid_E   = r_valid_E;
  assign pc_E      = r_pl.pc;
  assign imm_E     = r_pl.imm;
  assign op1_E     = r_pl.op1;
  assign op2_E     = r_pl.op2;
  assign type_E    = r_pl.typ;
  assign rd_E      = r_pl.rd;
  assign load_E    = r_pl.load;
  assign ctrl_E    = r_pl.ctrl;
  assign cnt_issue = r_cnt_issue;
  assign cnt_stall = r_cnt_stall;
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: scoreboard of accepted instructions checked
// at every execute handshake, plus direct checks of control/counter state.
module tb_id_ex_reg;
  logic        clk = 1'b0;
  logic        rst, flush, valid_D, ready_D, load_D, stall_D;
  logic [31:0] pc_D, imm_D, rf_rdata1, rf_rdata2, forward_rs1, forward_rs2;
  logic [4:0]  type_D, rs1_D, rs2_D, rd_D;
  logic [15:0] ctrl_D;
  logic        valid_forward_rs1, valid_forward_rs2, ready_E, valid_E, load_E;
  logic [31:0] pc_E, imm_E, op1_E, op2_E, cnt_issue, cnt_stall;
  logic [4:0]  type_E, rd_E;
  logic [15:0] ctrl_E;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_D(valid_D), .ready_D(ready_D),
    .pc_D(pc_D), .imm_D(imm_D), .type_D(type_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rd_D(rd_D), .load_D(load_D), .ctrl_D(ctrl_D), .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2), .stall_D(stall_D), .valid_forward_rs1(valid_forward_rs1),
    .valid_forward_rs2(valid_forward_rs2), .forward_rs1(forward_rs1),
    .forward_rs2(forward_rs2), .ready_E(ready_E), .valid_E(valid_E), .pc_E(pc_E),
    .imm_E(imm_E), .op1_E(op1_E), .op2_E(op2_E), .type_E(type_E), .rd_E(rd_E),
    .load_E(load_E), .ctrl_E(ctrl_E), .cnt_issue(cnt_issue), .cnt_stall(cnt_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one decode instruction; side fields derive from pc so the
  // scoreboard can rebuild them.
  task automatic present(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2);
    valid_D   = 1'b1;
    pc_D      = pc;
    imm_D     = pc ^ 32'h0000_1000;
    rd_D      = pc[6:2];
    load_D    = pc[2];
    ctrl_D    = pc[15:0] ^ 16'hA5A5;
    type_D    = pc[4:0];
    rs1_D     = r1;
    rf_rdata1 = d1;
    rs2_D     = r2;
    rf_rdata2 = d2;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] o1, input logic [31:0] o2);
    exp_t e;
    e.pc = pc; e.op1 = o1; e.op2 = o2;
    sb.push_back(e);
  endtask

  // Every execute handshake must deliver the oldest expected instruction.
  always @(negedge clk) begin
    if (!rst && valid_E && ready_E) begin
      if (sb.size() == 0) chk("sb_unexpected_out", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc",   pc_E,  e.pc);
        chk("sb_imm",  imm_E, e.pc ^ 32'h0000_1000);
        chk("sb_op1",  op1_E, e.op1);
        chk("sb_op2",  op2_E, e.op2);
        chk("sb_rd",   {27'd0, rd_E},   {27'd0, e.pc[6:2]});
        chk("sb_type", {27'd0, type_E}, {27'd0, e.pc[4:0]});
        chk("sb_load", {31'd0, load_E}, {31'd0, e.pc[2]});
        chk("sb_ctrl", {16'd0, ctrl_E}, {16'd0, e.pc[15:0] ^ 16'hA5A5});
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; valid_D = 1'b0; stall_D = 1'b0; ready_E = 1'b1;
    pc_D = '0; imm_D = '0; type_D = '0; rs1_D = '0; rs2_D = '0; rd_D = '0;
    load_D = 1'b0; ctrl_D = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    valid_forward_rs1 = 1'b0; valid_forward_rs2 = 1'b0;
    forward_rs1 = '0; forward_rs2 = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_valid", {31'd0, valid_E}, 32'd0);
    chk("rst_op1", op1_E, 32'd0);
    chk("rst_issue", cnt_issue, 32'd0);
    chk("rst_stall", cnt_stall, 32'd0);
    chk("rst_ready", {31'd0, ready_D}, 32'd1);

    // back-to-back issue
    present(32'h0, 5'd1, 32'h10, 5'd2, 32'h20); push(32'h0, 32'h10, 32'h20); tick();
    chk("b2b_v0", {31'd0, valid_E}, 32'd1);
    present(32'h4, 5'd1, 32'h14, 5'd2, 32'h24); push(32'h4, 32'h14, 32'h24); tick();
    chk("b2b_v1", {31'd0, valid_E}, 32'd1);
    present(32'h8, 5'd1, 32'h18, 5'd2, 32'h28); push(32'h8, 32'h18, 32'h28); tick();
    chk("b2b_v2", {31'd0, valid_E}, 32'd1);
    chk("b2b_pc2", pc_E, 32'h8);
    chk("b2b_issue", cnt_issue, 32'd3);
    valid_D = 1'b0; tick();
    chk("b2b_drain", {31'd0, valid_E}, 32'd0);

    // forwarding, x0 override, rs2 forward
    present(32'h100, 5'd5, 32'h11, 5'd0, 32'h55);
    valid_forward_rs1 = 1'b1; forward_rs1 = 32'hDEAD;
    push(32'h100, 32'hDEAD, 32'h0); tick();
    present(32'h104, 5'd0, 32'h77, 5'd3, 32'h33);
    forward_rs1 = 32'hBEEF;
    push(32'h104, 32'h0, 32'h33); tick();
    present(32'h108, 5'd2, 32'h22, 5'd7, 32'h70);
    valid_forward_rs1 = 1'b0; valid_forward_rs2 = 1'b1; forward_rs2 = 32'hCAFE;
    push(32'h108, 32'h22, 32'hCAFE); tick();
    valid_D = 1'b0; valid_forward_rs2 = 1'b0; tick();

    // load-use stall: operand re-sampled once the stall drops
    present(32'h200, 5'd4, 32'h40, 5'd6, 32'h60); stall_D = 1'b1; #1;
    chk("lu_ready", {31'd0, ready_D}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, valid_E}, 32'd0);
    stall_D = 1'b0; rf_rdata1 = 32'h44;
    push(32'h200, 32'h44, 32'h60); tick();
    chk("lu_issue_v", {31'd0, valid_E}, 32'd1);
    chk("lu_stall_cnt", cnt_stall, 32'd1);
    chk("lu_issue_cnt", cnt_issue, 32'd7);

    // backpressure: accept alongside the held instruction's fire_out
    present(32'h300, 5'd1, 32'h31, 5'd2, 32'h32); push(32'h300, 32'h31, 32'h32); tick();
    ready_E = 1'b0;
    present(32'h304, 5'd1, 32'h35, 5'd2, 32'h36); push(32'h304, 32'h35, 32'h36); #1;
    chk("bp_ready", {31'd0, ready_D}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_pc", pc_E, 32'h300);
      chk("bp_hold_v", {31'd0, valid_E}, 32'd1);
      chk("bp_hold_op1", op1_E, 32'h31);
    end
    ready_E = 1'b1; #1;
    chk("bp_release_ready", {31'd0, ready_D}, 32'd1);
    tick();
    chk("bp_next_pc", pc_E, 32'h304);
    chk("bp_issue_cnt", cnt_issue, 32'd9);

    // flush with held and incoming instruction; stall in the same cycle not counted
    ready_E = 1'b0;
    present(32'h400, 5'd1, 32'h41, 5'd2, 32'h42);
    flush = 1'b1; stall_D = 1'b1;
    void'(sb.pop_front());
    tick();
    flush = 1'b0; stall_D = 1'b0; valid_D = 1'b0;
    chk("fl_valid", {31'd0, valid_E}, 32'd0);
    chk("fl_issue", cnt_issue, 32'd9);
    chk("fl_stall", cnt_stall, 32'd1);

    // reset mid-stream
    present(32'h500, 5'd1, 32'h51, 5'd2, 32'h52); tick();
    chk("pre_rst_op1", op1_E, 32'h51);
    present(32'h504, 5'd1, 32'h53, 5'd2, 32'h54); rst = 1'b1; tick();
    rst = 1'b0; valid_D = 1'b0; ready_E = 1'b1;
    chk("mrst_valid", {31'd0, valid_E}, 32'd0);
    chk("mrst_op1", op1_E, 32'd0);
    chk("mrst_pc", pc_E, 32'd0);
    chk("mrst_issue", cnt_issue, 32'd0);
    chk("mrst_stall", cnt_stall, 32'd0);

    // restart after reset
    present(32'h600, 5'd3, 32'h63, 5'd0, 32'h64); push(32'h600, 32'h63, 32'h0); tick();
    valid_D = 1'b0; tick();
    chk("post_issue", cnt_issue, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
